// File: rtl/wb_burst_master_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wb_burst_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WFETCH,
    S_WBEAT,
    S_RBEAT
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Cycle-type tag for a beat: single-beat commands use classic cycles,
  // longer bursts announce incrementing beats and flag the final one.
  function automatic logic [2:0] cti_for(input logic single, input logic last);
    if (single) return CTI_CLASSIC;
    if (last)   return CTI_END;
    return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_burst_master_ack_timeout.sv
// Watchdog for a strobed beat: raises expire on the TMO-th consecutive
// strobed cycle without an acknowledge.
module wb_ack_timeout #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TMO + 1);

  // tmo_cnt_q holds the number of already-elapsed unacknowledged cycles, so
  // the current cycle is the TMO-th when the count equals TMO-1.
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign expire = stb && !ack && (tmo_cnt_q == CW'(TMO - 1));

  // Next count: restart on ack, idle strobe or abort; otherwise count up.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    tmo_cnt_d = tmo_cnt_q;
    if (!stb || ack || expire) tmo_cnt_d = '0;
    else                       tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master in front of the SDRAM controller.
// Takes one command at a time, streams write beats in or read beats out,
// and abandons a beat whose acknowledge never arrives.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int DW     = 32,
  parameter int APP_AW = 26,
  parameter int LEN_W  = 8,
  parameter int TMO    = 255
) (
  input  logic                sys_clk,
  input  logic                wb_rst_i,
  input  logic                sdr_init_done,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [APP_AW-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DW/8-1:0]     cmd_sel,
  input  logic [DW-1:0]       wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic                wb_cyc_i,
  output logic                wb_stb_i,
  output logic                wb_we_i,
  output logic [APP_AW-1:0]   wb_addr_i,
  output logic [DW-1:0]       wb_dat_i,
  output logic [DW/8-1:0]     wb_sel_i,
  output logic [2:0]          wb_cti_i,
  input  logic                wb_ack_o,
  input  logic [DW-1:0]       wb_dat_o,
  output logic                busy,
  output logic                timeout_err
);

  localparam int                SW   = DW / 8;
  localparam logic [APP_AW-1:0] STEP = APP_AW'(SW);

  state_t              state_q, state_d;
  logic [APP_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                we_q, we_d;
  logic [DW-1:0]       dat_q, dat_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [2:0]          cti_q, cti_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                tmo_err_q, tmo_err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                busy_q, busy_d;

  logic                expire;
  logic                ack_v;
  logic                cmd_fire;
  logic                wr_fire;
  logic                last_beat;
  logic [LEN_W-1:0]    beat_nxt;

  // An ack only counts while a beat is actually strobed.
  assign ack_v     = wb_ack_o && stb_q;
  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign wr_fire   = wr_valid && wr_ready_q;
  assign last_beat = (beat_q == len_q);
  assign beat_nxt  = beat_q + LEN_W'(1);

  wb_ack_timeout #(.TMO(TMO)) u_ack_timeout (
    .clk    (sys_clk),
    .rst    (wb_rst_i),
    .stb    (stb_q),
    .ack    (ack_v),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic; a pending command wins over a late init drop because
  // cmd_ready was already shown to the requester this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (sdr_init_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_fire)           state_d = cmd_we ? S_WFETCH : S_RBEAT;
        else if (!sdr_init_done) state_d = S_INIT;
      end
      S_WFETCH: if (wr_fire) state_d = S_WBEAT;
      S_WBEAT: begin
        if (ack_v)       state_d = last_beat ? S_IDLE : S_WFETCH;
        else if (expire) state_d = S_IDLE;
      end
      S_RBEAT:  if ((ack_v && last_beat) || expire) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // Output and datapath next values; handshake readies follow the next state
  // so that they are registered yet valid in the cycle the state is entered.
  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    dat_d       = dat_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    cti_d       = cti_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    tmo_err_d   = 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_WFETCH);
    busy_d      = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          sel_d  = cmd_sel;
          we_d   = cmd_we;
          beat_d = '0;
          cyc_d  = 1'b1;
          stb_d  = !cmd_we;
          cti_d  = cti_for(cmd_len == '0, cmd_len == '0);
        end
      end
      S_WFETCH: begin
        if (wr_fire) begin
          dat_d = wr_data;
          stb_d = 1'b1;
        end
      end
      S_WBEAT, S_RBEAT: begin
        if (ack_v) begin
          if (state_q == S_RBEAT) begin
            rd_data_d  = wb_dat_o;
            rd_valid_d = 1'b1;
          end
          if (last_beat) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            cti_d = CTI_CLASSIC;
          end else begin
            addr_d = addr_q + STEP;
            beat_d = beat_nxt;
            cti_d  = cti_for(len_q == '0, beat_nxt == len_q);
            // Writes drop strobe until the next data word is fetched.
            if (state_q == S_WBEAT) stb_d = 1'b0;
          end
        end else if (expire) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          cti_d     = CTI_CLASSIC;
          tmo_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset clears everything, abandoning any burst.
  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) begin
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      dat_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      cti_q       <= cti_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      tmo_err_q   <= tmo_err_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wr_ready    = wr_ready_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wb_cyc_i    = cyc_q;
  assign wb_stb_i    = stb_q;
  assign wb_we_i     = we_q;
  assign wb_addr_i   = addr_q;
  assign wb_dat_i    = dat_q;
  assign wb_sel_i    = sel_q;
  assign wb_cti_i    = cti_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: directed vector table, random
// bursts against a transaction-level model, and hand-written corner cases.
module tb_wb_burst_master;

  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int LW  = 8;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          sys_clk = 1'b0;
  logic          wb_rst_i;
  logic          sdr_init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [SW-1:0] cmd_sel;
  logic [DW-1:0] wr_data  = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic          wb_ack_o = 1'b0;
  logic [DW-1:0] wb_dat_o = '0;
  logic          busy;
  logic          timeout_err;

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(.DW(DW), .APP_AW(AW), .LEN_W(LW), .TMO(TMO)) dut (
    .sys_clk       (sys_clk),
    .wb_rst_i      (wb_rst_i),
    .sdr_init_done (sdr_init_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_sel       (cmd_sel),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_addr_i     (wb_addr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_cti_i      (wb_cti_i),
    .wb_ack_o      (wb_ack_o),
    .wb_dat_o      (wb_dat_o),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model and monitors ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t         beat_log[$];
  logic [DW-1:0] rd_log[$];
  logic [DW-1:0] wq[$];

  int            ack_delay  = 0;
  int            ack_limit  = -1;
  int            acks_given = 0;
  int            wait_cnt   = 0;
  int            hang_run   = 0;
  bit            acked_prev = 0;
  logic          cyc_after_ack = 1'b1;
  logic [DW-1:0] salt = '0;

  int tmo_pulses = 0, overlap = 0, fetch_run = 0, max_run = 0, cyc_rises = 0;
  logic cyc_prev = 1'b0;

  int gap_after = -1, gap_len = 0, wr_taken = 0, wr_hold = 0;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return {a, 6'h2B} ^ s;
  endfunction

  // Slave: ack a strobed beat after ack_delay waiting cycles, log the beat.
  always @(negedge sys_clk) begin
    if (acked_prev) cyc_after_ack = wb_cyc_i;
    acked_prev = 0;
    if (wb_cyc_i && wb_stb_i) begin
      if ((ack_limit < 0 || acks_given < ack_limit) && wait_cnt >= ack_delay) begin
        wb_ack_o = 1'b1;
        wb_dat_o = rd_word(wb_addr_i, salt);
        beat_log.push_back('{wb_addr_i, wb_cti_i, wb_we_i, wb_sel_i, wb_dat_i});
        acks_given++;
        wait_cnt   = 0;
        acked_prev = 1;
      end else begin
        wb_ack_o = 1'b0;
        wait_cnt++;
      end
    end else begin
      wb_ack_o = 1'b0;
      if (wait_cnt > 0) hang_run = wait_cnt;
      wait_cnt = 0;
    end
  end

  // Write-data source with an optional hole after a chosen word.
  always @(negedge sys_clk) begin
    if (wr_hold > 0) begin
      wr_valid = 1'b0;
      wr_hold--;
    end else if (wq.size() > 0) begin
      wr_valid = 1'b1;
      wr_data  = wq[0];
      if (wr_ready) begin
        void'(wq.pop_front());
        if (wr_taken == gap_after) wr_hold = gap_len;
        wr_taken++;
      end
    end else begin
      wr_valid = 1'b0;
    end
  end

  // Passive monitor.
  always @(negedge sys_clk) begin
    if (rd_valid) rd_log.push_back(rd_data);
    if (timeout_err) tmo_pulses++;
    if (cmd_ready && wr_ready) overlap++;
    if (wb_cyc_i && !wb_stb_i) begin
      fetch_run++;
      if (fetch_run > max_run) max_run = fetch_run;
    end else begin
      fetch_run = 0;
    end
    if (wb_cyc_i && !cyc_prev) cyc_rises++;
    cyc_prev = wb_cyc_i;
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    beat_log.delete();
    rd_log.delete();
    tmo_pulses    = 0;
    overlap       = 0;
    max_run       = 0;
    cyc_rises     = 0;
    acks_given    = 0;
    cyc_after_ack = 1'b1;
  endtask

  task automatic send_cmd(input bit we, input logic [AW-1:0] a, input int len,
                          input logic [SW-1:0] sel, output int waited);
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = LW'(len);
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge sys_clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_bound", 64'(waited), 64'd0);
      cmd_valid = 1'b0;
    end else begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_cyc"},       64'(wb_cyc_i),    0);
    check({p, "_stb"},       64'(wb_stb_i),    0);
    check({p, "_we"},        64'(wb_we_i),     0);
    check({p, "_addr"},      64'(wb_addr_i),   0);
    check({p, "_dat"},       64'(wb_dat_i),    0);
    check({p, "_sel"},       64'(wb_sel_i),    0);
    check({p, "_cti"},       64'(wb_cti_i),    0);
    check({p, "_cmd_ready"}, 64'(cmd_ready),   0);
    check({p, "_wr_ready"},  64'(wr_ready),    0);
    check({p, "_rd_valid"},  64'(rd_valid),    0);
    check({p, "_rd_data"},   64'(rd_data),     0);
    check({p, "_busy"},      64'(busy),        0);
    check({p, "_tmo_err"},   64'(timeout_err), 0);
  endtask

  // One complete burst checked against the transaction-level model:
  // beat k lands at (addr + 4k) mod 2^AW with the cycle-type the bus rules imply.
  task automatic run_burst(input bit we, input logic [AW-1:0] a, input int len,
                           input logic [SW-1:0] sel, input int delay,
                           input int g_after, input int g_len, input logic [DW-1:0] d0);
    logic [DW-1:0] exp_w[$];
    logic [AW-1:0] ea;
    logic [2:0]    ecti;
    logic [DW-1:0] w;
    int            waited;
    clear_logs();
    ack_delay = delay;
    ack_limit = -1;
    salt      = $urandom;
    gap_after = g_after;
    gap_len   = g_len;
    wr_taken  = 0;
    wr_hold   = 0;
    if (we) begin
      for (int k = 0; k <= len; k++) begin
        w = (k == 0) ? d0 : $urandom;
        exp_w.push_back(w);
        wq.push_back(w);
      end
    end
    send_cmd(we, a, len, sel, waited);
    wait_idle("burst");
    check("beats", 64'(beat_log.size()), 64'(len + 1));
    for (int k = 0; k <= len && k < beat_log.size(); k++) begin
      ea   = AW'((longint'(a) + 4 * k) % (64'd1 << AW));
      ecti = (len == 0) ? 3'b000 : ((k == len) ? 3'b111 : 3'b010);
      check($sformatf("beat%0d_addr", k), 64'(beat_log[k].addr), 64'(ea));
      check($sformatf("beat%0d_cti", k),  64'(beat_log[k].cti),  64'(ecti));
      check($sformatf("beat%0d_we", k),   64'(beat_log[k].we),   64'(we));
      check($sformatf("beat%0d_sel", k),  64'(beat_log[k].sel),  64'(sel));
      if (we) check($sformatf("beat%0d_wdat", k), 64'(beat_log[k].dat), 64'(exp_w[k]));
    end
    if (we) begin
      check("rd_pulses_on_write", 64'(rd_log.size()), 0);
      check("wdata_consumed", 64'(wq.size()), 0);
    end else begin
      check("rd_pulses", 64'(rd_log.size()), 64'(len + 1));
      for (int k = 0; k <= len && k < rd_log.size(); k++) begin
        ea = AW'((longint'(a) + 4 * k) % (64'd1 << AW));
        check($sformatf("rd%0d_data", k), 64'(rd_log[k]), 64'(rd_word(ea, salt)));
      end
    end
    check("cyc_after_last_ack", 64'(cyc_after_ack), 0);
    check("ready_overlap", 64'(overlap), 0);
    check("cyc_single_rise", 64'(cyc_rises), 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    int            len;
    logic [SW-1:0] sel;
    int            delay;
    int            gap_after;
    int            gap_len;
    logic [DW-1:0] d0;
    int            exp_beats;
    logic [AW-1:0] exp_last_addr;
    logic [2:0]    exp_last_cti;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit after %0d comparisons", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int bad;
    logic [AW-1:0] a;
    bit we;
    int len, gl;

    vecs[0] = '{1'b1, 26'h0000100, 0, 4'hF, 3, -1, 0, 32'hDEADBEEF, 1, 26'h0000100, 3'b000};
    vecs[1] = '{1'b0, 26'h3FFFFF8, 3, 4'hF, 0, -1, 0, 32'h0,        4, 26'h0000004, 3'b111};
    vecs[2] = '{1'b1, 26'h0002000, 7, 4'hF, 0,  2, 5, 32'h12345678, 8, 26'h000201C, 3'b111};
    vecs[3] = '{1'b0, 26'h0000040, 1, 4'h3, 2, -1, 0, 32'h0,        2, 26'h0000044, 3'b111};
    vecs[4] = '{1'b1, 26'h3FFFFFC, 1, 4'hC, 1, -1, 0, 32'hCAFEF00D, 2, 26'h0000000, 3'b111};

    wb_rst_i      = 1'b1;
    sdr_init_done = 1'b0;
    cmd_valid     = 1'b0;
    cmd_we        = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    cmd_sel       = '0;

    // Reset state.
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");

    // Init gate: command held while the controller is not ready.
    wb_rst_i  = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 26'h0000200;
    cmd_len   = '0;
    cmd_sel   = 4'hF;
    cmd_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (cmd_ready || wb_cyc_i) bad++;
    end
    check("init_gate_blocked", 64'(bad), 0);
    check("init_busy", 64'(busy), 1);
    clear_logs();
    ack_delay = 0;
    ack_limit = -1;
    salt = $urandom;
    sdr_init_done = 1'b1;
    send_cmd(1'b0, 26'h0000200, 0, 4'hF, waited);
    check("init_accept_within_2", 64'(waited + 1 <= 2), 1);
    wait_idle("init_cmd");
    check("init_cmd_beats", 64'(beat_log.size()), 1);
    check("init_cmd_rdata", 64'(rd_log.size() > 0 ? rd_log[0] : '0),
          64'(rd_word(26'h0000200, salt)));

    // Table-driven bursts.
    foreach (vecs[i]) begin
      run_burst(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].sel, vecs[i].delay,
                vecs[i].gap_after, vecs[i].gap_len, vecs[i].d0);
      check($sformatf("vec%0d_beats", i), 64'(beat_log.size()), 64'(vecs[i].exp_beats));
      if (beat_log.size() > 0) begin
        check($sformatf("vec%0d_last_addr", i), 64'(beat_log[$].addr), 64'(vecs[i].exp_last_addr));
        check($sformatf("vec%0d_last_cti", i),  64'(beat_log[$].cti),  64'(vecs[i].exp_last_cti));
      end
      if (vecs[i].gap_len > 0)
        check($sformatf("vec%0d_gap_stb_low", i), 64'(max_run >= vecs[i].gap_len), 1);
    end

    // Random bursts against the model.
    for (int r = 0; r < 12; r++) begin
      we  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) a = 26'h3FFFFFC - AW'(4 * $urandom_range(0, 5));
      else                           a = AW'($urandom) & ~AW'(3);
      gl = $urandom_range(0, 3);
      run_burst(we, a, len, SW'($urandom_range(1, 15)), $urandom_range(0, 3),
                $urandom_range(0, 3), gl, $urandom);
    end

    // Timeout: first beat acked, second beat never acked.
    clear_logs();
    hang_run  = 0;
    ack_delay = 0;
    ack_limit = 1;
    send_cmd(1'b0, 26'h0000800, 3, 4'hF, waited);
    wait_idle("timeout");
    check("tmo_beats", 64'(beat_log.size()), 1);
    check("tmo_stb_cycles", 64'(hang_run), 64'(TMO));
    check("tmo_err_pulses", 64'(tmo_pulses), 1);
    check("tmo_cyc", 64'(wb_cyc_i), 0);
    check("tmo_busy", 64'(busy), 0);
    check("tmo_rd_pulses", 64'(rd_log.size()), 1);
    run_burst(1'b0, 26'h0000900, 1, 4'hF, 0, -1, 0, '0);

    // Reset mid-burst during beat 2 of an 8-beat write.
    clear_logs();
    ack_delay = 1;
    ack_limit = -1;
    gap_after = -1;
    wr_taken  = 0;
    for (int k = 0; k < 8; k++) wq.push_back($urandom);
    send_cmd(1'b1, 26'h0004000, 7, 4'hF, waited);
    bad = 0;
    while (!(beat_log.size() == 2 && wb_stb_i && wb_addr_i == 26'h0004008) && bad < 200) begin
      @(negedge sys_clk);
      bad++;
    end
    check("rst_reached_beat2", 64'(bad < 200), 1);
    wb_rst_i      = 1'b1;
    sdr_init_done = 1'b0;
    @(negedge sys_clk);
    check_all_zero("rst_mid");
    check("rst_no_extra_beat", 64'(beat_log.size()), 2);
    @(negedge sys_clk);
    wq.delete();
    wb_rst_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_init_cmd_ready", 64'(cmd_ready), 0);
    check("rst_init_busy", 64'(busy), 1);
    sdr_init_done = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_idle_cmd_ready", 64'(cmd_ready), 1);
    check("rst_idle_busy", 64'(busy), 0);
    run_burst(1'b1, 26'h0000300, 2, 4'hF, 0, -1, 0, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
